// File: rtl/arb_pkg.sv
// Shared definitions for the age-matrix arbiter: size limit, triangular
// index of the age matrix and one-hot to binary conversion.
package arb_pkg;

   // Largest supported number of requesters.
   localparam int MAX_ARB_N = 16;

   // Flat position of age bit older[i][j] (i<j) in the upper triangle of an
   // n x n matrix, rows packed back to back.
   function automatic int tri_idx(input int n, input int i, input int j);
      return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
   endfunction

   // Binary index of the set bit of a one-hot vector; 0 for an all-zero input.
   function automatic logic [3:0] onehot_to_bin(input logic [MAX_ARB_N-1:0] oh);
      logic [3:0] b;
      b = 4'd0;
      for (int k = 0; k < MAX_ARB_N; k++) begin
         if (oh[k]) begin
            b = b | 4'(k);
         end else begin
            b = b;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/age_matrix.sv
// Age matrix for the oldest-first arbiter. Holds one bit per requester pair
// (upper triangle only, older[j][i] is read as ~older[i][j]), selects the
// oldest active requester and re-ages the youngest set on every edge.
module age_matrix
   import arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] request_i,
   input  logic [N-1:0] youngest_i,
   input  logic [N-1:0] grant_oh_i,
   input  logic         grant_v_i,
   output logic [N-1:0] winner_o
);

   localparam int NP = (N * (N - 1)) / 2;

   logic [NP-1:0] older_q;
   logic [NP-1:0] older_d;
   // Full square view of the matrix; the diagonal reads as 1 so a requester
   // never blocks itself.
   logic [N-1:0]  older_m [N];

   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            if (gi < gj) begin : g_upper
               localparam int K = tri_idx(N, gi, gj);
               assign older_m[gi][gj] = older_q[K];

               // Next age bit for the pair (gi, gj):
               //  only gi young      -> gj becomes older (bit 0)
               //  only gj young      -> gi becomes older (bit 1)
               //  both young         -> the granted one is youngest,
               //                        otherwise lower index is older
               //  neither young      -> unchanged
               assign older_d[K] =
                  (youngest_i[gi] &  youngest_i[gj]) ? ~(grant_v_i & grant_oh_i[gi]) :
                  (youngest_i[gi] & ~youngest_i[gj]) ? 1'b0 :
                  (~youngest_i[gi] & youngest_i[gj]) ? 1'b1 :
                  older_q[K];
            end else if (gi > gj) begin : g_lower
               assign older_m[gi][gj] = ~older_q[tri_idx(N, gj, gi)];
            end else begin : g_diag
               assign older_m[gi][gj] = 1'b1;
            end
         end

         // Requester gi wins when it requests and is older than every other
         // active requester.
         assign winner_o[gi] = request_i[gi] & (&(older_m[gi] | ~request_i));
      end
   endgenerate

   // Age matrix register; reset order is lower index older.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         older_q <= {NP{1'b1}};
      end else begin
         older_q <= older_d;
      end
   end

endmodule

// File: rtl/age_arbiter.sv
// N-way oldest-first arbiter in front of the shared output buffer.
// Requests are served in arrival order tracked by an age matrix; a requester
// holding its request after a grant re-queues as youngest (round robin under
// saturation). buffer_full_i suppresses grants but arrivals keep aging.
// Optional build macro: AGE_ARB_REG_GRANT_EN registers the grant outputs
// (one cycle latency); undefined gives combinational outputs.
module age_arbiter
   import arb_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   request,
   input  logic           buffer_full_i,
   output logic [N-1:0]   grant,
   output logic           grant_v_o,
   output logic [IDW-1:0] grant_id_o
);

   generate
      if ((N < 2) || (N > MAX_ARB_N)) begin : g_bad_n
         $error("age_arbiter: N=%0d outside supported range 2..%0d", N, MAX_ARB_N);
      end
   endgenerate

   logic [N-1:0]   pending_q;
   logic [N-1:0]   winner_s;
   logic [N-1:0]   grant_s;
   logic [N-1:0]   arrival_s;
   logic [N-1:0]   youngest_s;
   logic           issue_s;
   logic           grant_v_s;
   logic [IDW-1:0] grant_id_s;

   // Grant decision, arrivals and youngest set. Reset gates the grant so
   // outputs are 0 immediately while rst is low.
   always_comb begin
      issue_s    = (|request) & ~buffer_full_i & rst;
      if (issue_s) begin
         grant_s = winner_s;
      end else begin
         grant_s = {N{1'b0}};
      end
      grant_v_s  = |grant_s;
      grant_id_s = IDW'(onehot_to_bin(MAX_ARB_N'(grant_s)));
      arrival_s  = request & ~pending_q;
      youngest_s = arrival_s | grant_s;
   end

   age_matrix #(
      .N (N)
   ) u_age_matrix (
      .clk_i      (clk),
      .rst_ni     (rst),
      .request_i  (request),
      .youngest_i (youngest_s),
      .grant_oh_i (grant_s),
      .grant_v_i  (grant_v_s),
      .winner_o   (winner_s)
   );

   // Request history used to detect arrivals; sampled regardless of back-pressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= {N{1'b0}};
      end else begin
         pending_q <= request;
      end
   end

`ifdef AGE_ARB_REG_GRANT_EN
   logic [N-1:0]   grant_q;
   logic           grant_v_q;
   logic [IDW-1:0] grant_id_q;

   // Output registers: present the decision taken at the previous edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q    <= {N{1'b0}};
         grant_v_q  <= 1'b0;
         grant_id_q <= {IDW{1'b0}};
      end else begin
         grant_q    <= grant_s;
         grant_v_q  <= grant_v_s;
         grant_id_q <= grant_id_s;
      end
   end

   assign grant      = grant_q;
   assign grant_v_o  = grant_v_q;
   assign grant_id_o = grant_id_q;
`else
   assign grant      = grant_s;
   assign grant_v_o  = grant_v_s;
   assign grant_id_o = grant_id_s;
`endif

endmodule

// File: tb/tb_age_arbiter.sv
// Directed bench for age_arbiter with N=4. Inputs change on the falling
// edge and outputs are sampled 1 time unit later.
module tb_age_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] request;
   logic       buffer_full;
   logic [3:0] grant;
   logic       grant_v_o;
   logic [1:0] grant_id_o;

   int vectors_applied;
   int miscompares;

   age_arbiter #(
      .N (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .request       (request),
      .buffer_full_i (buffer_full),
      .grant         (grant),
      .grant_v_o     (grant_v_o),
      .grant_id_o    (grant_id_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors_applied++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_id(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   task automatic check_outs(input string tag, input logic [3:0] eg);
      check_eq({tag, "_grant"}, 32'(grant), 32'(eg));
      check_eq({tag, "_gv"},    32'(grant_v_o), 32'(|eg));
      check_eq({tag, "_id"},    32'(grant_id_o), 32'(exp_id(eg)));
   endtask

   task automatic apply(input string tag, input logic [3:0] r, input logic f, input logic [3:0] eg);
      @(negedge clk);
      request     = r;
      buffer_full = f;
      #1;
      check_outs(tag, eg);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b0;
      request     = 4'b0000;
      buffer_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      vectors_applied = 0;
      miscompares     = 0;
      rst             = 1'b0;
      request         = 4'b0000;
      buffer_full     = 1'b0;
      #2;
      check_outs("reset", 4'b0000);
      do_reset();

`ifdef AGE_ARB_REG_GRANT_EN
      // Saturation with registered outputs: same order, one cycle later.
      apply("rsat0", 4'b1111, 1'b0, 4'b0000);
      apply("rsat1", 4'b1111, 1'b0, 4'b0001);
      apply("rsat2", 4'b1111, 1'b0, 4'b0010);
      apply("rsat3", 4'b1111, 1'b0, 4'b0100);
      apply("rsat4", 4'b1111, 1'b0, 4'b1000);
      apply("rsat5", 4'b1111, 1'b0, 4'b0001);
`else
      // Saturation: round robin from requester 0.
      apply("sat0", 4'b1111, 1'b0, 4'b0001);
      apply("sat1", 4'b1111, 1'b0, 4'b0010);
      apply("sat2", 4'b1111, 1'b0, 4'b0100);
      apply("sat3", 4'b1111, 1'b0, 4'b1000);
      apply("sat4", 4'b1111, 1'b0, 4'b0001);

      // Arrival order while full: 3, then 1, then 0.
      do_reset();
      apply("arr0", 4'b1000, 1'b1, 4'b0000);
      apply("arr1", 4'b1010, 1'b1, 4'b0000);
      apply("arr2", 4'b1011, 1'b1, 4'b0000);
      apply("arr3", 4'b1011, 1'b0, 4'b1000);
      apply("arr4", 4'b0011, 1'b0, 4'b0010);
      apply("arr5", 4'b0001, 1'b0, 4'b0001);

      // Back-pressure holds grants off; both arrive together, lower index first.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         apply($sformatf("bp%0d", k), 4'b0110, 1'b1, 4'b0000);
      end
      apply("bp_rel0", 4'b0110, 1'b0, 4'b0010);
      apply("bp_rel1", 4'b0110, 1'b0, 4'b0100);

      // Drop and rejoin of requester 2 after 0 and 1 were served.
      do_reset();
      apply("dr0", 4'b1111, 1'b0, 4'b0001);
      apply("dr1", 4'b1111, 1'b0, 4'b0010);
      apply("dr2", 4'b1011, 1'b0, 4'b1000);
      apply("dr3", 4'b1111, 1'b0, 4'b0100);
      apply("dr4", 4'b1111, 1'b0, 4'b0001);

      // Reset pulled mid-cycle: outputs clear at once, order restarts at 0.
      do_reset();
      apply("mr0", 4'b1111, 1'b0, 4'b0001);
      apply("mr1", 4'b1111, 1'b0, 4'b0010);
      rst = 1'b0;
      #1;
      check_outs("mr_low", 4'b0000);
      @(posedge clk);
      #1;
      check_outs("mr_hold", 4'b0000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outs("mr_rel0", 4'b0001);
      apply("mr_rel1", 4'b1111, 1'b0, 4'b0010);
      apply("mr_rel2", 4'b1111, 1'b0, 4'b0100);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
